lvds_tx_sched: RTL and testbench
================================

Name: lvds_tx_sched

Overview:
Packet scheduler that sequences the LVDS DAC transmit path. Once the TX_EN register bit is set, it reads a packet from the tx packet buffer, framed with preamble and sync bytes, and hands bytes one at a time to the LVDS byte serializer through a valid/ready handshake. It then waits an inter-packet gap and repeats while TX_EN stays high. It sits between regwrap (config and status) and the tx_dac_fsm serializer stage.

Parameters:
ADDR_W, 8, tx packet buffer address width
PRE_BYTES, 4, number of preamble bytes per packet (1..15)
PRE_PAT, 8'h55, preamble byte value
SYNC_PAT, 8'hD5, sync byte sent after the preamble

Ports:
clk  in  1  system clock
reset  in  1  reset; one clock; reset is asynchronous and active-high
cfg_tx_en  in  1  TX_EN bit from the DAC register
cfg_pkt_len  in  8  payload length in bytes; 0 means no transmission
cfg_gap  in  8  idle clk cycles between packets
buf_rd_en  out  1  buffer read strobe
buf_rd_addr  out  ADDR_W  buffer read address
buf_rd_data  in  8  buffer data, valid exactly 1 clk after buf_rd_en
ser_valid  out  1  byte valid to serializer
ser_data  out  8  byte to serializer
ser_ready  in  1  serializer accepts a byte when ser_valid and ser_ready are both high
lvds_en  out  1  LVDS line driver enable
busy  out  1  high in every state except IDLE
pkt_done  out  1  one-clk pulse when a packet completes
tx_abort  out  1  one-clk pulse when a packet is cut short by TX_EN going low
pkt_count  out  16  completed-packet counter; wraps 16'hFFFF -> 0

Behaviour:
- Reset values: every output 0, state IDLE, all counters 0. Reset mid-packet drops ser_valid and lvds_en immediately (asynchronous), with no abort pulse.
- Handshake: once ser_valid is asserted, ser_data is held stable and ser_valid stays high until accepted. A transfer occurs on any clk edge where ser_valid and ser_ready are both high.
- States:
  - IDLE: when cfg_tx_en=1 and cfg_pkt_len!=0, latch cfg_pkt_len and cfg_gap, set byte index to 0, go to PRE.
  - PRE: present PRE_PAT; after PRE_BYTES transfers, go to SYNC.
  - SYNC: present SYNC_PAT; on transfer, go to FETCH.
  - FETCH: pulse buf_rd_en for 1 clk with buf_rd_addr = byte index, zero-extended; go to LOAD.
  - LOAD: capture buf_rd_data into ser_data, assert ser_valid, go to SEND.
  - SEND: on transfer, increment the index. If index = latched length, go to CRC when the macro is enabled, otherwise to GAP. Else go to FETCH.
  - GAP: ser_valid=0. Count the latched gap cycles; gap 0 means exit on the next clk. On exit, if cfg_tx_en=1 re-latch config and go to PRE, else go to IDLE.
- lvds_en is 1 from entry to PRE until entry to GAP.
- pkt_done and a pkt_count increment happen on the cycle GAP is entered after a full packet.
- cfg_tx_en falling mid-packet: finish any byte already presented (ser_valid stays high until accepted). Then go to IDLE, pulse tx_abort, and do not increment pkt_count or pulse pkt_done.
- cfg_tx_en falling during GAP: complete the gap, then go to IDLE with no abort.
- Config changes mid-packet are ignored until the next latch.
- Minimum payload byte cadence: 3 clks (FETCH, LOAD, SEND with ready already high).
- Payload address never exceeds 254. If ADDR_W<8, the address is truncated (wraps).

Optional Feature:
LVDS_TX_CRC_EN.
- Defined: a CRC state after SEND presents CRC-8 (poly 0x07, init 0x00, MSB-first, no reflection) over the payload bytes only, computed at transfer time. The packet completes on that byte's transfer.
- Undefined: no CRC state; the packet ends after the last payload byte.

Decomposition:
- Package lvds_pkg: state enum type, PRE_PAT and SYNC_PAT defaults, CRC8_POLY, and a function crc8_byte(crc, data).
- One natural sub-module: lvds_gap_timer, a loadable down-counter with a done flag, used for the gap.

Test Plan:
- Length 3, buffer {0xA1,0xB2,0xC3}, gap 10, ser_ready tied 1, TX_EN pulsed high for one packet only -> serializer sees 55 55 55 55 D5 A1 B2 C3, then pkt_done, pkt_count=1, lvds_en low in GAP, then IDLE.
- Same config, ser_ready high only 1 clk in 8 -> identical byte order; ser_data never changes while ser_valid=1 and ready=0.
- TX_EN held high with length 2 and gap 0 -> back-to-back packets; pkt_count increments once per packet; preamble restarts each packet.
- TX_EN dropped while the second payload byte is presented with ready=0 -> byte held until ready, then tx_abort pulse, IDLE, and pkt_count unchanged.
- cfg_pkt_len=0 with TX_EN=1 -> busy, ser_valid and lvds_en stay 0; reset asserted mid-PRE -> all outputs 0 asynchronously, and the schedule restarts cleanly after release.
- With LVDS_TX_CRC_EN, payload {0x01,0x02} -> trailing byte 0x1B; pkt_count wrap checked by preload via force at 0xFFFF -> 0 after one packet.

Source files
------------

// File: rtl/lvds_pkg.sv
// Shared types, default patterns and CRC-8 helper for the LVDS transmit scheduler.
package lvds_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StSync,
        StFetch,
        StLoad,
        StSend,
        StCrc,
        StGap
    } state_e;

    localparam logic [7:0] PRE_PAT_DEF  = 8'h55;
    localparam logic [7:0] SYNC_PAT_DEF = 8'hD5;
    localparam logic [7:0] CRC8_POLY    = 8'h07;

    // One byte of CRC-8, MSB-first, no reflection.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/lvds_gap_timer.sv
// Loadable down-counter; done is high while the count is zero.
module lvds_gap_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/lvds_tx_sched.sv
// LVDS transmit packet scheduler: preamble, sync, buffered payload, optional CRC-8, gap.
// Optional trailing CRC byte is enabled by defining LVDS_TX_CRC_EN.
module lvds_tx_sched
    import lvds_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned PRE_BYTES = 4,
    parameter logic [7:0]  PRE_PAT   = PRE_PAT_DEF,
    parameter logic [7:0]  SYNC_PAT  = SYNC_PAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_tx_en,
    input  logic [7:0]        cfg_pkt_len,
    input  logic [7:0]        cfg_gap,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] buf_rd_addr,
    input  logic [7:0]        buf_rd_data,
    output logic              ser_valid,
    output logic [7:0]        ser_data,
    input  logic              ser_ready,
    output logic              lvds_en,
    output logic              busy,
    output logic              pkt_done,
    output logic              tx_abort,
    output logic [15:0]       pkt_count
);

    state_e      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [3:0]  pre_cnt_q, pre_cnt_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  gap_q, gap_d;
    logic [7:0]  data_q, data_d;
    logic [15:0] count_q, count_d;
    logic        done_q, done_d;
    logic        abort_q, abort_d;
`ifdef LVDS_TX_CRC_EN
    logic [7:0]  crc_q, crc_d;
`endif

    logic xfer;
    logic start;
    logic gap_load;
    logic gap_done;
    logic pre_last;
    logic last_byte;

    lvds_gap_timer #(
        .W(8)
    ) u_gap_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (gap_load),
        .load_val(gap_q),
        .done    (gap_done)
    );

    assign xfer      = ser_valid & ser_ready;
    assign pre_last  = (pre_cnt_q == 4'(PRE_BYTES - 1));
    assign last_byte = ((idx_q + 8'd1) == len_q);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pre_cnt_d = pre_cnt_q;
        len_d     = len_q;
        gap_d     = gap_q;
        data_d    = data_q;
        count_d   = count_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        gap_load  = 1'b0;
        start     = 1'b0;
`ifdef LVDS_TX_CRC_EN
        crc_d     = crc_q;
`endif
        case (state_q)
            StIdle: begin
                if (cfg_tx_en && (cfg_pkt_len != 8'd0)) begin
                    start = 1'b1;
                end
            end
            StPre: begin
                if (xfer) begin
                    if (!cfg_tx_en) begin
                        abort_d = 1'b1;
                    end else if (pre_last) begin
                        state_d   = StSync;
                        pre_cnt_d = 4'd0;
                    end else begin
                        pre_cnt_d = pre_cnt_q + 4'd1;
                    end
                end
            end
            StSync: begin
                if (xfer) begin
                    if (!cfg_tx_en) begin
                        abort_d = 1'b1;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                if (!cfg_tx_en) begin
                    abort_d = 1'b1;
                end else begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                // Read data is valid in this cycle; hold it for the whole handshake.
                data_d  = buf_rd_data;
                state_d = StSend;
            end
            StSend: begin
                if (xfer) begin
                    idx_d = idx_q + 8'd1;
`ifdef LVDS_TX_CRC_EN
                    crc_d = crc8_byte(crc_q, data_q);
                    if (!cfg_tx_en) begin
                        abort_d = 1'b1;
                    end else if (last_byte) begin
                        state_d = StCrc;
                    end else begin
                        state_d = StFetch;
                    end
`else
                    // A transferred final byte completes the packet even if TX_EN just fell.
                    if (last_byte) begin
                        done_d = 1'b1;
                    end else if (!cfg_tx_en) begin
                        abort_d = 1'b1;
                    end else begin
                        state_d = StFetch;
                    end
`endif
                end
            end
`ifdef LVDS_TX_CRC_EN
            StCrc: begin
                if (xfer) begin
                    done_d = 1'b1;
                end
            end
`endif
            StGap: begin
                if (gap_done) begin
                    if (cfg_tx_en && (cfg_pkt_len != 8'd0)) begin
                        start = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (start) begin
            state_d   = StPre;
            len_d     = cfg_pkt_len;
            gap_d     = cfg_gap;
            idx_d     = 8'd0;
            pre_cnt_d = 4'd0;
`ifdef LVDS_TX_CRC_EN
            crc_d     = 8'd0;
`endif
        end
        if (abort_d) begin
            state_d = StIdle;
        end
        if (done_d) begin
            state_d  = StGap;
            gap_load = 1'b1;
            count_d  = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= 8'd0;
            pre_cnt_q <= 4'd0;
            len_q     <= 8'd0;
            gap_q     <= 8'd0;
            data_q    <= 8'd0;
            count_q   <= 16'd0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
`ifdef LVDS_TX_CRC_EN
            crc_q     <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pre_cnt_q <= pre_cnt_d;
            len_q     <= len_d;
            gap_q     <= gap_d;
            data_q    <= data_d;
            count_q   <= count_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
`ifdef LVDS_TX_CRC_EN
            crc_q     <= crc_d;
`endif
        end
    end

    always_comb begin
        ser_data = 8'h00;
        case (state_q)
            StPre:   ser_data = PRE_PAT;
            StSync:  ser_data = SYNC_PAT;
            StSend:  ser_data = data_q;
`ifdef LVDS_TX_CRC_EN
            StCrc:   ser_data = crc_q;
`endif
            default: ser_data = 8'h00;
        endcase
    end

    // Decoded from state so an asynchronous reset drops them immediately.
`ifdef LVDS_TX_CRC_EN
    assign ser_valid = (state_q == StPre) || (state_q == StSync) || (state_q == StSend) ||
                       (state_q == StCrc);
`else
    assign ser_valid = (state_q == StPre) || (state_q == StSync) || (state_q == StSend);
`endif
    assign lvds_en     = (state_q != StIdle) && (state_q != StGap);
    assign busy        = (state_q != StIdle);
    assign buf_rd_en   = (state_q == StFetch);
    assign buf_rd_addr = ADDR_W'(idx_q);
    assign pkt_done    = done_q;
    assign tx_abort    = abort_q;
    assign pkt_count   = count_q;

endmodule

// File: tb/tb_lvds_tx_sched.sv
// Scoreboard bench for lvds_tx_sched; expected bytes queued by stimulus, checked by a monitor.
module tb_lvds_tx_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_tx_en;
    logic [7:0]  cfg_pkt_len;
    logic [7:0]  cfg_gap;
    logic        buf_rd_en;
    logic [7:0]  buf_rd_addr;
    logic [7:0]  buf_rd_data = 8'h00;
    logic        ser_valid;
    logic [7:0]  ser_data;
    logic        ser_ready;
    logic        lvds_en;
    logic        busy;
    logic        pkt_done;
    logic        tx_abort;
    logic [15:0] pkt_count;

    logic [7:0]  mem [256];
    logic [7:0]  exp_q [$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          abort_cnt = 0;
    logic [15:0] model_count = 16'd0;
    int          mode = 2;
    int          cyc = 0;
    logic        held = 1'b0;
    logic [7:0]  held_data = 8'h00;

    lvds_tx_sched dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_tx_en  (cfg_tx_en),
        .cfg_pkt_len(cfg_pkt_len),
        .cfg_gap    (cfg_gap),
        .buf_rd_en  (buf_rd_en),
        .buf_rd_addr(buf_rd_addr),
        .buf_rd_data(buf_rd_data),
        .ser_valid  (ser_valid),
        .ser_data   (ser_data),
        .ser_ready  (ser_ready),
        .lvds_en    (lvds_en),
        .busy       (busy),
        .pkt_done   (pkt_done),
        .tx_abort   (tx_abort),
        .pkt_count  (pkt_count)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

`ifdef LVDS_TX_CRC_EN
    function automatic logic [7:0] crc_model(input int len);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < len; i++) begin
            c = c ^ mem[i];
            for (int b = 0; b < 8; b++) c = c[7] ? (8'(c << 1) ^ 8'h07) : 8'(c << 1);
        end
        return c;
    endfunction
`endif

    task automatic push_hdr();
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
    endtask

    task automatic push_pkt(input int len);
        push_hdr();
        for (int i = 0; i < len; i++) exp_q.push_back(mem[i]);
`ifdef LVDS_TX_CRC_EN
        exp_q.push_back(crc_model(len));
`endif
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (pkt_done) return;
        end
        check(name, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        check(name, 32'd0, 32'd1);
    endtask

    // Ready driver: mode 0 always ready, mode 1 ready one clk in eight, mode 2 manual.
    initial forever begin
        @(posedge clk);
        #1;
        if (mode == 0) begin
            ser_ready = 1'b1;
        end else if (mode == 1) begin
            cyc++;
            ser_ready = (cyc % 8 == 0);
        end
    end

    // Monitor: a byte transfers at the posedge following a negedge with valid and ready.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            held = 1'b0;
        end else begin
            if (held && ser_valid) check("hold_data", {24'd0, ser_data}, {24'd0, held_data});
            if (ser_valid && ser_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'd0, ser_data}, 32'hFFFF_FFFF);
                end else begin
                    check("ser_byte", {24'd0, ser_data}, {24'd0, exp_q.pop_front()});
                end
            end
            held      = ser_valid && !ser_ready;
            held_data = ser_data;
            if (pkt_done) begin
                done_cnt++;
                model_count = model_count + 16'd1;
                check("pkt_count_on_done", {16'd0, pkt_count}, {16'd0, model_count});
                check("lvds_en_gap", {31'd0, lvds_en}, 32'd0);
            end
            if (tx_abort) abort_cnt++;
        end
    end

    initial begin
        int gap_cyc;
        int d0;
        logic bad;
        reset       = 1'b1;
        cfg_tx_en   = 1'b0;
        cfg_pkt_len = 8'd0;
        cfg_gap     = 8'd0;
        ser_ready   = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, ser_valid}, 32'd0);
        check("rst_lvds_en", {31'd0, lvds_en}, 32'd0);
        check("rst_rd_en", {31'd0, buf_rd_en}, 32'd0);
        check("rst_flags", {30'd0, pkt_done, tx_abort}, 32'd0);
        check("rst_count", {16'd0, pkt_count}, 32'd0);
        reset = 1'b0;

        // Single packet, ready always high, gap 10.
        mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3;
        cfg_pkt_len = 8'd3;
        cfg_gap     = 8'd10;
        mode        = 0;
        push_pkt(3);
        cfg_tx_en = 1'b1;
        wait_done("t1_done_timeout");
        cfg_tx_en = 1'b0;
        gap_cyc = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            gap_cyc++;
        end
        check("t1_gap_cycles", gap_cyc, 32'd11);
        check("t1_count", {16'd0, pkt_count}, 32'd1);
        check("t1_abort", abort_cnt, 32'd0);

        // Sparse ready: same bytes, data must hold while stalled.
        mode = 1;
        push_pkt(3);
        cfg_tx_en = 1'b1;
        wait_done("t2_done_timeout");
        cfg_tx_en = 1'b0;
        wait_idle("t2_idle_timeout");
        check("t2_count", {16'd0, pkt_count}, 32'd2);

        // Back-to-back packets, length 2, gap 0.
        mode = 0;
        mem[0] = 8'h11; mem[1] = 8'h22;
        cfg_pkt_len = 8'd2;
        cfg_gap     = 8'd0;
        d0 = done_cnt;
        repeat (3) push_pkt(2);
        cfg_tx_en = 1'b1;
        wait_done("t3_done0_timeout");
        wait_done("t3_done1_timeout");
        wait_done("t3_done2_timeout");
        cfg_tx_en = 1'b0;
        wait_idle("t3_idle_timeout");
        check("t3_done_cnt", done_cnt - d0, 32'd3);
        check("t3_count", {16'd0, pkt_count}, 32'd5);

        // Abort while the second payload byte is stalled.
        mode = 2;
        @(posedge clk); #1 ser_ready = 1'b1;
        mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3;
        cfg_pkt_len = 8'd3;
        cfg_gap     = 8'd2;
        d0 = done_cnt;
        push_hdr();
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hB2);
        cfg_tx_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (buf_rd_en && buf_rd_addr == 8'd1) break;
        end
        @(posedge clk); #1 ser_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t4_presented", {23'd0, ser_valid, ser_data}, {23'd0, 1'b1, 8'hB2});
        @(posedge clk); #1 cfg_tx_en = 1'b0;
        repeat (4) @(negedge clk);
        check("t4_still_held", {22'd0, busy, ser_valid, ser_data}, {22'd0, 2'b11, 8'hB2});
        @(posedge clk); #1 ser_ready = 1'b1;
        wait_idle("t4_idle_timeout");
        check("t4_abort_cnt", abort_cnt, 32'd1);
        check("t4_no_done", done_cnt - d0, 32'd0);
        check("t4_count", {16'd0, pkt_count}, 32'd5);

        // Zero length never starts.
        cfg_pkt_len = 8'd0;
        cfg_tx_en   = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy || ser_valid || lvds_en) bad = 1'b1;
        end
        check("t5_len0_quiet", {31'd0, bad}, 32'd0);
        cfg_tx_en = 1'b0;

        // Asynchronous reset in the preamble with ready low.
        cfg_pkt_len = 8'd3;
        cfg_gap     = 8'd1;
        @(posedge clk); #1 ser_ready = 1'b0;
        cfg_tx_en = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_in_pre", {30'd0, busy, ser_valid}, 32'd3);
        @(posedge clk); #1 reset = 1'b1;
        model_count = 16'd0;
        #1;
        check("t6_async_outs", {26'd0, busy, ser_valid, lvds_en, buf_rd_en, pkt_done, tx_abort},
              32'd0);
        check("t6_async_count", {16'd0, pkt_count}, 32'd0);
        repeat (2) @(negedge clk);
        push_pkt(3);
        reset = 1'b0;
        @(posedge clk); #1 ser_ready = 1'b1;
        wait_done("t6_done_timeout");
        cfg_tx_en = 1'b0;
        wait_idle("t6_idle_timeout");
        check("t6_count", {16'd0, pkt_count}, 32'd1);

        // Counter wrap from preloaded 0xFFFF; payload {01,02}.
        @(negedge clk);
        force dut.count_q = 16'hFFFF;
        @(negedge clk);
        release dut.count_q;
        model_count = 16'hFFFF;
        @(negedge clk);
        check("t7_preload", {16'd0, pkt_count}, 32'h0000_FFFF);
        mem[0] = 8'h01; mem[1] = 8'h02;
        cfg_pkt_len = 8'd2;
        push_hdr();
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
`ifdef LVDS_TX_CRC_EN
        exp_q.push_back(8'h1B);
`endif
        cfg_tx_en = 1'b1;
        wait_done("t7_done_timeout");
        cfg_tx_en = 1'b0;
        wait_idle("t7_idle_timeout");
        check("t7_wrap", {16'd0, pkt_count}, 32'd0);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
